// File: rtl/axil_vf_pkg.sv
// axil_vf_pkg: shared definitions for the per-function AXI-lite slaves.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   func_id_t               : function ID carried on awuser/aruser
//   strb_merge()            : byte-enable merge of new data onto old data,
//                             sized for the widest supported data bus;
//                             callers size-cast in and out.
package axil_vf_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int FUNC_ID_W = 8;
  typedef logic [FUNC_ID_W-1:0] func_id_t;

  localparam int MERGE_W  = 256;
  localparam int MERGE_SW = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] strb_merge(
    input logic [MERGE_W-1:0]  old_v,
    input logic [MERGE_W-1:0]  new_v,
    input logic [MERGE_SW-1:0] strb
  );
    logic [MERGE_W-1:0] m;
    m = old_v;
    for (int b = 0; b < MERGE_SW; b++)
      if (strb[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
    return m;
  endfunction

endpackage

// File: rtl/axil_vf_wr_join.sv
// axil_vf_wr_join: joins independent AW and W beats into one write command.
//   AW/W in    : each beat is captured into a holding register; its ready
//                drops while held and returns once the B handshake completes.
//   wr_exec    : one-cycle strobe, both beats held and no B pending.
//   wr_addr/user/prot/data/strb : the held beat contents.
//   wr_resp in : response decided by the consumer for the executing write.
//   B out      : bvalid rises the cycle after wr_exec, holds until bready.
module axil_vf_wr_join #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [USER_WIDTH-1:0] awuser,
  input  logic [2:0]            awprot,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  output logic                  wr_exec,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [USER_WIDTH-1:0] wr_user,
  output logic [2:0]            wr_prot,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [STRB_WIDTH-1:0] wr_strb,
  input  logic [1:0]            wr_resp
);

  logic aw_held, w_held;

  assign awready = !aw_held;
  assign wready  = !w_held;
  assign wr_exec = aw_held & w_held & !bvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      wr_addr <= '0;
      wr_user <= '0;
      wr_prot <= '0;
      wr_data <= '0;
      wr_strb <= '0;
      bvalid  <= 1'b0;
      bresp   <= '0;
    end else begin
      if (awvalid && awready) begin
        aw_held <= 1'b1;
        wr_addr <= awaddr;
        wr_user <= awuser;
        wr_prot <= awprot;
      end
      if (wvalid && wready) begin
        w_held  <= 1'b1;
        wr_data <= wdata;
        wr_strb <= wstrb;
      end
      // Beats stay held while B is pending so only one write is in flight.
      if (wr_exec) begin
        bvalid <= 1'b1;
        bresp  <= wr_resp;
      end else if (bvalid && bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/axil_vf_regfile.sv
// axil_vf_regfile: AXI-lite register slave with one bank of REG_COUNT
// registers per PCIe function; bank chosen by awuser/aruser, register by
// address bits [ADDR_LSB +: log2(REG_COUNT)]. Out-of-range function IDs get
// SLVERR (reads return 0).
//   s_axil_*     : AXI-lite slave (AW/W/B/AR/R)
//   reg_out      : all registers, bank f reg r at (f*REG_COUNT+r)*DATA_WIDTH
//   reg_wr_pulse : one-cycle pulse per register on an OKAY write, aligned
//                  with the first cycle reg_out shows the new value
// Optional build macro AXIL_VF_REGFILE_PROT_CHECK_EN: register 0 of every
// bank only accepts privileged writes (awprot[0]=1); others get SLVERR.
module axil_vf_regfile
  import axil_vf_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 16,
  parameter int STRB_WIDTH        = DATA_WIDTH / 8,
  parameter int FUNCTION_ID_WIDTH = 8,
  parameter int FUNC_COUNT        = 4,
  parameter int REG_COUNT         = 8
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [ADDR_WIDTH-1:0]                    s_axil_awaddr,
  input  logic [FUNCTION_ID_WIDTH-1:0]             s_axil_awuser,
  input  logic [2:0]                               s_axil_awprot,
  input  logic                                     s_axil_awvalid,
  output logic                                     s_axil_awready,
  input  logic [DATA_WIDTH-1:0]                    s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]                    s_axil_wstrb,
  input  logic                                     s_axil_wvalid,
  output logic                                     s_axil_wready,
  output logic [1:0]                               s_axil_bresp,
  output logic                                     s_axil_bvalid,
  input  logic                                     s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]                    s_axil_araddr,
  input  logic [FUNCTION_ID_WIDTH-1:0]             s_axil_aruser,
  input  logic [2:0]                               s_axil_arprot,
  input  logic                                     s_axil_arvalid,
  output logic                                     s_axil_arready,
  output logic [DATA_WIDTH-1:0]                    s_axil_rdata,
  output logic [1:0]                               s_axil_rresp,
  output logic                                     s_axil_rvalid,
  input  logic                                     s_axil_rready,
  output logic [FUNC_COUNT*REG_COUNT*DATA_WIDTH-1:0] reg_out,
  output logic [FUNC_COUNT*REG_COUNT-1:0]          reg_wr_pulse
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(REG_COUNT);
  // One extra bit so the ID compare is at full width with no aliasing.
  localparam logic [FUNCTION_ID_WIDTH:0] FUNC_LIM = (FUNCTION_ID_WIDTH+1)'(FUNC_COUNT);

  logic [FUNC_COUNT-1:0][REG_COUNT-1:0][DATA_WIDTH-1:0] regs;

  logic                         wr_exec;
  logic [ADDR_WIDTH-1:0]        wr_addr;
  logic [FUNCTION_ID_WIDTH-1:0] wr_user;
  logic [2:0]                   wr_prot;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [STRB_WIDTH-1:0]        wr_strb;
  logic [1:0]                   wr_resp;
  logic [IDX_W-1:0]             wr_idx;
  logic                         id_ok, prot_ok, wr_ok;

  axil_vf_wr_join #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .USER_WIDTH (FUNCTION_ID_WIDTH)
  ) u_wr_join (
    .clk     (clk),
    .rst_n   (rst_n),
    .awaddr  (s_axil_awaddr),
    .awuser  (s_axil_awuser),
    .awprot  (s_axil_awprot),
    .awvalid (s_axil_awvalid),
    .awready (s_axil_awready),
    .wdata   (s_axil_wdata),
    .wstrb   (s_axil_wstrb),
    .wvalid  (s_axil_wvalid),
    .wready  (s_axil_wready),
    .bresp   (s_axil_bresp),
    .bvalid  (s_axil_bvalid),
    .bready  (s_axil_bready),
    .wr_exec (wr_exec),
    .wr_addr (wr_addr),
    .wr_user (wr_user),
    .wr_prot (wr_prot),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_resp (wr_resp)
  );

  assign wr_idx = wr_addr[ADDR_LSB +: IDX_W];
  assign id_ok  = {1'b0, wr_user} < FUNC_LIM;

`ifdef AXIL_VF_REGFILE_PROT_CHECK_EN
  assign prot_ok = (wr_idx != '0) || wr_prot[0];
`else
  assign prot_ok = 1'b1;
`endif

  assign wr_ok   = id_ok & prot_ok;
  assign wr_resp = wr_ok ? RESP_OKAY : RESP_SLVERR;

  // Register storage: one flop group per (bank, reg); upper address bits
  // are not decoded, the crossbar already selected this region.
  for (genvar f = 0; f < FUNC_COUNT; f++) begin : g_bank
    for (genvar r = 0; r < REG_COUNT; r++) begin : g_reg
      logic [DATA_WIDTH-1:0] q;
      logic                  p;
      logic                  hit;

      assign hit = wr_exec & wr_ok & (wr_user == FUNCTION_ID_WIDTH'(f)) &
                   (wr_idx == IDX_W'(r));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q <= '0;
          p <= 1'b0;
        end else begin
          p <= hit;
          if (hit)
            q <= DATA_WIDTH'(strb_merge(MERGE_W'(q), MERGE_W'(wr_data), MERGE_SW'(wr_strb)));
        end
      end

      assign regs[f][r]                  = q;
      assign reg_wr_pulse[f*REG_COUNT+r] = p;
    end
  end

  assign reg_out = regs;

  // Read path: registered R beat, sampled from current register contents,
  // so a write executing in the same cycle is not yet visible.
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_ok;

  assign rd_idx         = s_axil_araddr[ADDR_LSB +: IDX_W];
  assign rd_ok          = {1'b0, s_axil_aruser} < FUNC_LIM;
  assign s_axil_arready = !s_axil_rvalid || s_axil_rready;

  always_comb begin
    rd_val = '0;
    for (int f = 0; f < FUNC_COUNT; f++)
      for (int r = 0; r < REG_COUNT; r++)
        if (s_axil_aruser == FUNCTION_ID_WIDTH'(f) && rd_idx == IDX_W'(r))
          rd_val = regs[f][r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rdata  <= '0;
      s_axil_rresp  <= '0;
    end else if (s_axil_arvalid && s_axil_arready) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rdata  <= rd_ok ? rd_val : '0;
      s_axil_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axil_arprot, s_axil_araddr, wr_addr, wr_prot};

endmodule

// File: tb/tb_axil_vf_regfile.sv
// Bench for axil_vf_regfile (default parameters: 4 banks x 8 regs x 32b).
// A register-array model follows the function/strobe rules; a monitor
// compares reg_out and reg_wr_pulse against it every cycle, and directed
// tasks check handshakes, responses and read data.
module tb_axil_vf_regfile;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   s_axil_awaddr = '0;
  logic [7:0]    s_axil_awuser = '0;
  logic [2:0]    s_axil_awprot = '0;
  logic          s_axil_awvalid = 1'b0;
  logic          s_axil_awready;
  logic [31:0]   s_axil_wdata = '0;
  logic [3:0]    s_axil_wstrb = '0;
  logic          s_axil_wvalid = 1'b0;
  logic          s_axil_wready;
  logic [1:0]    s_axil_bresp;
  logic          s_axil_bvalid;
  logic          s_axil_bready = 1'b0;
  logic [15:0]   s_axil_araddr = '0;
  logic [7:0]    s_axil_aruser = '0;
  logic [2:0]    s_axil_arprot = '0;
  logic          s_axil_arvalid = 1'b0;
  logic          s_axil_arready;
  logic [31:0]   s_axil_rdata;
  logic [1:0]    s_axil_rresp;
  logic          s_axil_rvalid;
  logic          s_axil_rready = 1'b0;
  logic [1023:0] reg_out;
  logic [31:0]   reg_wr_pulse;

  always #5 clk = ~clk;

  axil_vf_regfile dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awuser(s_axil_awuser),
    .s_axil_awprot(s_axil_awprot), .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_aruser(s_axil_aruser),
    .s_axil_arprot(s_axil_arprot), .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int bcount = 0;
  int hits [32];

  logic [31:0] mdl [4][8];
  logic [7:0]  p_user = '0;
  logic [2:0]  p_idx = '0;
  logic [31:0] p_data = '0;
  logic [3:0]  p_strb = '0;
  logic [2:0]  p_prot = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic bit model_ok(input logic [7:0] user, input logic [2:0] idx, input logic [2:0] prot);
    bit ok;
    ok = (user < 8'd4);
`ifdef AXIL_VF_REGFILE_PROT_CHECK_EN
    if (idx == 3'd0 && !prot[0]) ok = 1'b0;
`else
    if (idx == 3'd0 && prot == 3'd7) ok = ok; // protection has no effect in this build
`endif
    return ok;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] m;
    m = o;
    for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = n[b*8 +: 8];
    return m;
  endfunction

  function automatic logic [31:0] exp_rdata(input logic [7:0] user, input logic [15:0] addr);
    logic [2:0] ix;
    ix = addr[4:2];
    return (user < 8'd4) ? mdl[user[1:0]][ix] : 32'h0;
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] user);
    return (user < 8'd4) ? 2'b00 : 2'b10;
  endfunction

  task automatic model_clear();
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 8; r++) mdl[f][r] = 32'h0;
  endtask

  // Runs every cycle after reset: applies the pending write when its B
  // response first appears, then checks all registers and pulses.
  task automatic monitor();
    logic        bv_q;
    logic [31:0] exp_p;
    logic [1023:0] ev;
    bv_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bv_q = 1'b0;
        continue;
      end
      exp_p = '0;
      if (s_axil_bvalid && !bv_q && model_ok(p_user, p_idx, p_prot)) begin
        mdl[p_user[1:0]][p_idx] = merge(mdl[p_user[1:0]][p_idx], p_data, p_strb);
        exp_p[{p_user[1:0], p_idx}] = 1'b1;
      end
      bv_q = s_axil_bvalid;
      if (s_axil_bvalid && s_axil_bready) bcount++;
      for (int i = 0; i < 32; i++) if (reg_wr_pulse[i]) hits[i]++;
      chk("reg_wr_pulse", 64'(reg_wr_pulse), 64'(exp_p));
      for (int f = 0; f < 4; f++)
        for (int r = 0; r < 8; r++) ev[(f*8+r)*32 +: 32] = mdl[f][r];
      total_cnt++;
      if (reg_out === ev) pass_cnt++;
      else begin
        for (int i = 0; i < 32; i++)
          if (reg_out[i*32 +: 32] !== ev[i*32 +: 32]) begin
            $display("FAIL reg_out[f%0d r%0d]: got %h expected %h", i/8, i%8,
                     reg_out[i*32 +: 32], ev[i*32 +: 32]);
            break;
          end
      end
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] user, input logic [2:0] prot,
                          input logic [31:0] data, input logic [3:0] strb, input int w_lead,
                          output logic [1:0] resp);
    bit aw_done, w_done, acc_aw, acc_w;
    int cyc;
    p_user = user; p_idx = addr[4:2]; p_data = data; p_strb = strb; p_prot = prot;
    @(posedge clk); #1;
    s_axil_awaddr = addr; s_axil_awuser = user; s_axil_awprot = prot;
    s_axil_wdata = data; s_axil_wstrb = strb;
    s_axil_wvalid = 1'b1; s_axil_awvalid = (w_lead == 0);
    s_axil_bready = 1'b0;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (w_lead > 0 && w_done && !aw_done) begin
        chk("wready_low_while_held", 64'(s_axil_wready), 64'(0));
        chk("no_b_before_aw", 64'(s_axil_bvalid), 64'(0));
      end
      acc_aw = s_axil_awvalid && s_axil_awready;
      acc_w  = s_axil_wvalid && s_axil_wready;
      @(posedge clk); #1;
      if (acc_aw) begin s_axil_awvalid = 1'b0; aw_done = 1; end
      if (acc_w)  begin s_axil_wvalid = 1'b0;  w_done = 1;  end
      cyc++;
      if (w_lead > 0 && cyc == w_lead) s_axil_awvalid = 1'b1;
    end
    chk("aw_w_accepted", 64'(aw_done && w_done), 64'(1));
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_bready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!s_axil_bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("bvalid_seen", 64'(s_axil_bvalid), 64'(1));
    chk("b_latency", 64'(cyc), 64'(1));
    resp = s_axil_bresp;
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [7:0] user,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    @(posedge clk); #1;
    s_axil_araddr = addr; s_axil_aruser = user; s_axil_arvalid = 1'b1; s_axil_rready = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!s_axil_arready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("arready", 64'(s_axil_arready), 64'(1));
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    chk("r_latency", 64'(s_axil_rvalid), 64'(1));
    data = s_axil_rdata; resp = s_axil_rresp;
    @(posedge clk); #1;
  endtask

  task automatic read_chk(input string name, input logic [15:0] addr, input logic [7:0] user);
    logic [31:0] d;
    logic [1:0]  r;
    do_read(addr, user, d, r);
    chk({name, "_rdata"}, 64'(d), 64'(exp_rdata(user, addr)));
    chk({name, "_rresp"}, 64'(r), 64'(exp_rresp(user)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    logic [1:0]  r;
    int          b0;
    logic [15:0] bb_addr [4];
    logic [7:0]  bb_user [4];
    logic [31:0] bb_data [4];
    logic [1:0]  bb_resp [4];

    model_clear();
    for (int i = 0; i < 32; i++) hits[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_awready", 64'(s_axil_awready), 64'(1));
    chk("rst_wready", 64'(s_axil_wready), 64'(1));
    chk("rst_arready", 64'(s_axil_arready), 64'(1));
    chk("rst_bvalid", 64'(s_axil_bvalid), 64'(0));
    chk("rst_rvalid", 64'(s_axil_rvalid), 64'(0));
    chk("rst_bresp", 64'(s_axil_bresp), 64'(0));
    chk("rst_rresp", 64'(s_axil_rresp), 64'(0));
    chk("rst_rdata", 64'(s_axil_rdata), 64'(0));
    chk("rst_pulse", 64'(reg_wr_pulse), 64'(0));
    chk("rst_reg_out_zero", 64'(reg_out == '0), 64'(1));
    rst_n = 1'b1;
    fork monitor(); join_none

    // Basic write/readback on bank 2 reg 2.
    do_write(16'h0008, 8'd2, 3'b000, 32'hDEADBEEF, 4'hF, 0, resp);
    chk("wr1_bresp", 64'(resp), 64'(2'b00));
    chk("wr1_model", 64'(mdl[2][2]), 64'(32'hDEADBEEF));
    chk("wr1_reg_out", 64'(reg_out[18*32 +: 32]), 64'(32'hDEADBEEF));
    repeat (2) @(posedge clk);
    chk("wr1_pulse_once", 64'(hits[18]), 64'(1));
    do_read(16'h0008, 8'd2, d, r);
    chk("rd1_rdata", 64'(d), 64'(32'hDEADBEEF));
    chk("rd1_rresp", 64'(r), 64'(2'b00));

    // W three cycles ahead of AW: one write, one B.
    b0 = bcount;
    do_write(16'h0014, 8'd1, 3'b000, 32'h12345678, 4'hF, 3, resp);
    repeat (2) @(posedge clk);
    chk("wlead_bresp", 64'(resp), 64'(2'b00));
    chk("wlead_single_b", 64'(bcount - b0), 64'(1));
    read_chk("wlead", 16'h0014, 8'd1);

    // Out-of-range function IDs.
    do_write(16'h0004, 8'd4, 3'b000, 32'hFFFFFFFF, 4'hF, 0, resp);
    chk("badid4_bresp", 64'(resp), 64'(2'b10));
    do_write(16'h0008, 8'h84, 3'b000, 32'h0BAD0BAD, 4'hF, 0, resp);
    chk("badid84_bresp", 64'(resp), 64'(2'b10));
    do_read(16'h0008, 8'h84, d, r);
    chk("rd84_rdata", 64'(d), 64'(0));
    chk("rd84_rresp", 64'(r), 64'(2'b10));
    read_chk("rd4", 16'h0004, 8'd4);
    read_chk("rd2_after_bad", 16'h0008, 8'd2);

    // Byte strobes, zero strobe, ignored address bits.
    do_write(16'h000C, 8'd3, 3'b000, 32'h11223344, 4'hF, 0, resp);
    do_write(16'h000C, 8'd3, 3'b000, 32'hAABBCCDD, 4'h5, 0, resp);
    chk("strb5_bresp", 64'(resp), 64'(2'b00));
    do_read(16'h000C, 8'd3, d, r);
    chk("strb5_rdata", 64'(d), 64'(32'h11BB33DD));
    do_write(16'h000C, 8'd3, 3'b000, 32'h99999999, 4'h0, 0, resp);
    chk("strb0_bresp", 64'(resp), 64'(2'b00));
    repeat (2) @(posedge clk);
    chk("strb0_pulse_count", 64'(hits[27]), 64'(3));
    read_chk("hiaddr", 16'hFF0C, 8'd3);
    read_chk("loaddr", 16'h000F, 8'd3);

    // R stall: data held, arready low.
    do_write(16'h001C, 8'd1, 3'b000, 32'hCAFE0007, 4'hF, 0, resp);
    @(posedge clk); #1;
    s_axil_araddr = 16'h001C; s_axil_aruser = 8'd1; s_axil_arvalid = 1'b1; s_axil_rready = 1'b0;
    @(negedge clk);
    chk("stall_ar_accept", 64'(s_axil_arready), 64'(1));
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_rvalid", 64'(s_axil_rvalid), 64'(1));
      chk("stall_rdata", 64'(s_axil_rdata), 64'(32'hCAFE0007));
      chk("stall_arready", 64'(s_axil_arready), 64'(0));
    end
    @(posedge clk); #1;
    s_axil_rready = 1'b1;
    @(negedge clk);
    chk("unstall_arready", 64'(s_axil_arready), 64'(1));
    @(negedge clk);
    chk("unstall_rvalid_drop", 64'(s_axil_rvalid), 64'(0));

    // Back-to-back reads, one beat per cycle.
    bb_addr[0] = 16'h001C; bb_user[0] = 8'd1;
    bb_addr[1] = 16'h0008; bb_user[1] = 8'd2;
    bb_addr[2] = 16'h0000; bb_user[2] = 8'd4;
    bb_addr[3] = 16'h0014; bb_user[3] = 8'd1;
    for (int i = 0; i < 4; i++) begin
      bb_data[i] = exp_rdata(bb_user[i], bb_addr[i]);
      bb_resp[i] = exp_rresp(bb_user[i]);
    end
    for (int i = 0; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        s_axil_araddr = bb_addr[i]; s_axil_aruser = bb_user[i]; s_axil_arvalid = 1'b1;
      end else s_axil_arvalid = 1'b0;
      @(negedge clk);
      if (i < 4) chk("b2b_arready", 64'(s_axil_arready), 64'(1));
      if (i > 0) begin
        chk("b2b_rvalid", 64'(s_axil_rvalid), 64'(1));
        chk("b2b_rdata", 64'(s_axil_rdata), 64'(bb_data[i-1]));
        chk("b2b_rresp", 64'(s_axil_rresp), 64'(bb_resp[i-1]));
      end
    end
    chk("b2b_first_literal", 64'(bb_data[0]), 64'(32'hCAFE0007));

    // Read accepted in the cycle a write to the same register executes.
    do_write(16'h0004, 8'd0, 3'b001, 32'h00000001, 4'hF, 0, resp);
    p_user = 8'd0; p_idx = 3'd1; p_data = 32'h00000002; p_strb = 4'hF; p_prot = 3'b001;
    @(posedge clk); #1;
    s_axil_awaddr = 16'h0004; s_axil_awuser = 8'd0; s_axil_awprot = 3'b001;
    s_axil_wdata = 32'h00000002; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1; s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 16'h0004; s_axil_aruser = 8'd0; s_axil_arvalid = 1'b1;
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    @(negedge clk);
    chk("rw_rvalid", 64'(s_axil_rvalid), 64'(1));
    chk("rw_old_value", 64'(s_axil_rdata), 64'(32'h00000001));
    chk("rw_bvalid", 64'(s_axil_bvalid), 64'(1));
    chk("rw_bresp", 64'(s_axil_bresp), 64'(2'b00));
    @(posedge clk); #1;
    s_axil_bready = 1'b0;
    do_read(16'h0004, 8'd0, d, r);
    chk("rw_new_value", 64'(d), 64'(32'h00000002));

    // Register 0 privilege handling.
    do_write(16'h0000, 8'd0, 3'b000, 32'h00000055, 4'hF, 0, resp);
`ifdef AXIL_VF_REGFILE_PROT_CHECK_EN
    chk("prot_unpriv_bresp", 64'(resp), 64'(2'b10));
    do_read(16'h0000, 8'd0, d, r);
    chk("prot_unpriv_unchanged", 64'(d), 64'(0));
`else
    chk("prot_ignored_bresp", 64'(resp), 64'(2'b00));
`endif
    do_write(16'h0000, 8'd0, 3'b001, 32'h000000AA, 4'hF, 0, resp);
    chk("prot_priv_bresp", 64'(resp), 64'(2'b00));
    do_read(16'h0000, 8'd0, d, r);
    chk("prot_priv_rdata", 64'(d), 64'(32'h000000AA));

    // Reset while a W beat is held.
    @(posedge clk); #1;
    s_axil_wdata = 32'h77777777; s_axil_wstrb = 4'hF; s_axil_wvalid = 1'b1;
    @(posedge clk); #1;
    s_axil_wvalid = 1'b0;
    @(negedge clk);
    chk("midrst_wready_held", 64'(s_axil_wready), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("midrst_wready", 64'(s_axil_wready), 64'(1));
    chk("midrst_reg_out", 64'(reg_out == '0), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_write(16'h0018, 8'd3, 3'b000, 32'h0F0F0F0F, 4'hF, 0, resp);
    chk("postrst_bresp", 64'(resp), 64'(2'b00));
    read_chk("postrst", 16'h0018, 8'd3);
    read_chk("postrst_cleared", 16'h0008, 8'd2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
